// File: rtl/blake2_pkg.sv
// -----------------------------------------------------------------------------
// blake2_pkg
// Shared declarations for the BLAKE2 digest reader:
//   - state_t              : readout FSM state encoding
//   - BUS_WIDTH_DEFAULT    : default processor bus word width (bits)
//   - DIGEST_WIDTH_DEFAULT : default hash-engine digest width (bits)
//   - SWAP_MAX_W           : widest bus word byte_swap() can handle
//   - byte_swap()          : reverses the byte order of the low nbytes bytes
// -----------------------------------------------------------------------------
package blake2_pkg;

   localparam int BUS_WIDTH_DEFAULT    = 32;
   localparam int DIGEST_WIDTH_DEFAULT = 512;
   localparam int SWAP_MAX_W           = 256;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      SEND     = 2'd1,
      WAIT_LOW = 2'd2
   } state_t;

   // A package function cannot take a width parameter, so the word is passed
   // zero-extended to SWAP_MAX_W and only the low nbytes bytes are reversed.
   function automatic logic [SWAP_MAX_W-1:0] byte_swap(
      input logic [SWAP_MAX_W-1:0] w,
      input int                    nbytes
   );
      logic [SWAP_MAX_W-1:0] r;
      r = '0;
      for (int i = 0; i < SWAP_MAX_W/8; i++) begin
         if (i < nbytes) begin
            r[8*(nbytes-1-i) +: 8] = w[8*i +: 8];
         end
      end
      return r;
   endfunction

endpackage

// File: rtl/blake2_digest_reader.sv
// -----------------------------------------------------------------------------
// blake2_digest_reader
// Captures a hash-engine digest into a shadow register and streams it to the
// processor one bus word at a time with a valid/ready handshake, word 0 first
// (word 0 = digest[BUS_WIDTH-1:0]). One digest_valid level is read out exactly
// once; a new digest arriving mid-readout is ignored and flagged as overrun.
//
// Ports:
//   clk              in   single clock, rising edge
//   reset_n          in   synchronous active-low reset
//   digest_valid     in   engine digest-ready level
//   digest           in   engine digest value [DIGEST_WIDTH-1:0]
//   new_hash_request in   abort/restart pulse, highest priority
//   dout_ready       in   processor accepts dout this cycle
//   dout             out  current digest word [BUS_WIDTH-1:0]
//   dout_valid       out  dout holds a valid word
//   dout_last        out  dout is the final word
//   busy             out  readout in progress or waiting for digest_valid low
//   overrun          out  sticky: new digest arrived before readout finished
//
// Configuration:
//   DIGEST_READER_BYTESWAP_EN  when defined, each dout word is byte-reversed
//                              (byte 0 to the MSB byte); BUS_WIDTH must then be
//                              a multiple of 8 and at most SWAP_MAX_W.
// -----------------------------------------------------------------------------
module blake2_digest_reader
   import blake2_pkg::*;
#(
   parameter int BUS_WIDTH    = BUS_WIDTH_DEFAULT,
   parameter int DIGEST_WIDTH = DIGEST_WIDTH_DEFAULT
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    digest_valid,
   input  logic [DIGEST_WIDTH-1:0] digest,
   input  logic                    new_hash_request,
   input  logic                    dout_ready,
   output logic [BUS_WIDTH-1:0]    dout,
   output logic                    dout_valid,
   output logic                    dout_last,
   output logic                    busy,
   output logic                    overrun
);

   localparam int WORDS = DIGEST_WIDTH / BUS_WIDTH;
   localparam int PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

   state_t               state, state_nx;
   logic [PTR_W-1:0]     ptr, ptr_nx;
   logic                 capture;
   logic                 dv_prev;
   logic                 dv_rise_in_send;
   logic [BUS_WIDTH-1:0] shadow [WORDS];

   // Rising edge of digest_valid while a readout is still in progress.
   assign dv_rise_in_send = (state == SEND) && digest_valid && !dv_prev;

   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      capture  = 1'b0;
      if (new_hash_request) begin
         state_nx = IDLE;
         ptr_nx   = '0;
      end else begin
         case (state)
            IDLE: begin
               if (digest_valid) begin
                  capture  = 1'b1;
                  ptr_nx   = '0;
                  state_nx = SEND;
               end
            end
            SEND: begin
               if (dout_ready) begin
                  if (ptr == LAST_PTR) begin
                     // Pointer parks on the last word; it never wraps.
                     state_nx = digest_valid ? WAIT_LOW : IDLE;
                  end else begin
                     ptr_nx = ptr + 1'b1;
                  end
               end
            end
            WAIT_LOW: begin
               if (!digest_valid) begin
                  state_nx = IDLE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state   <= IDLE;
         ptr     <= '0;
         overrun <= 1'b0;
         dv_prev <= 1'b0;
         for (int i = 0; i < WORDS; i++) begin
            shadow[i] <= '0;
         end
      end else begin
         state   <= state_nx;
         ptr     <= ptr_nx;
         dv_prev <= digest_valid;
         if (new_hash_request) begin
            overrun <= 1'b0;
         end else if (dv_rise_in_send) begin
            overrun <= 1'b1;
         end
         if (capture) begin
            for (int i = 0; i < WORDS; i++) begin
               shadow[i] <= digest[i*BUS_WIDTH +: BUS_WIDTH];
            end
         end
      end
   end

   assign dout_valid = (state == SEND);
   assign dout_last  = dout_valid && (ptr == LAST_PTR);
   assign busy       = (state != IDLE);

`ifdef DIGEST_READER_BYTESWAP_EN
   logic [SWAP_MAX_W-1:0] wide_word;
   logic [SWAP_MAX_W-1:0] wide_swap;

   always_comb begin
      wide_word                  = '0;
      wide_word[BUS_WIDTH-1:0]   = shadow[ptr];
      wide_swap                  = byte_swap(wide_word, BUS_WIDTH/8);
   end

   assign dout = wide_swap[BUS_WIDTH-1:0];
`else
   assign dout = shadow[ptr];
`endif

endmodule

// File: tb/tb_blake2_digest_reader.sv
// -----------------------------------------------------------------------------
// tb_blake2_digest_reader
// Self-checking bench for blake2_digest_reader (BUS_WIDTH=32, DIGEST_WIDTH=512).
// A behavioural readout model is advanced on every rising edge and compared
// with the DUT on every falling edge; directed scenarios add literal checks.
// -----------------------------------------------------------------------------
module tb_blake2_digest_reader;

   localparam int BW    = 32;
   localparam int DW    = 512;
   localparam int WORDS = DW / BW;

   logic          clk = 1'b0;
   logic          reset_n;
   logic          digest_valid;
   logic [DW-1:0] digest;
   logic          new_hash_request;
   logic          dout_ready;
   logic [BW-1:0] dout;
   logic          dout_valid;
   logic          dout_last;
   logic          busy;
   logic          overrun;

   int checks = 0;
   int errors = 0;

   blake2_digest_reader #(.BUS_WIDTH(BW), .DIGEST_WIDTH(DW)) dut (
      .clk              (clk),
      .reset_n          (reset_n),
      .digest_valid     (digest_valid),
      .digest           (digest),
      .new_hash_request (new_hash_request),
      .dout_ready       (dout_ready),
      .dout             (dout),
      .dout_valid       (dout_valid),
      .dout_last        (dout_last),
      .busy             (busy),
      .overrun          (overrun)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural model ----------------
   // A readout is "active" while words remain to be delivered; "waiting" after
   // the last word while the same digest_valid level is still high.
   bit            m_active, m_waiting, m_ovr, m_prev_dv;
   int            m_idx;
   logic [BW-1:0] m_words [WORDS];

   function automatic logic [BW-1:0] present(input logic [BW-1:0] w);
`ifdef DIGEST_READER_BYTESWAP_EN
      return {w[7:0], w[15:8], w[23:16], w[31:24]};
`else
      return w;
`endif
   endfunction

   always @(posedge clk) begin
      if (!reset_n) begin
         m_active = 0; m_waiting = 0; m_ovr = 0; m_prev_dv = 0; m_idx = 0;
         for (int i = 0; i < WORDS; i++) m_words[i] = '0;
      end else begin
         if (new_hash_request) begin
            m_active = 0; m_waiting = 0; m_ovr = 0; m_idx = 0;
         end else if (m_active) begin
            if (digest_valid && !m_prev_dv) m_ovr = 1;
            if (dout_ready) begin
               if (m_idx == WORDS-1) begin
                  m_active  = 0;
                  m_waiting = digest_valid;
               end else begin
                  m_idx++;
               end
            end
         end else if (m_waiting) begin
            if (!digest_valid) m_waiting = 0;
         end else if (digest_valid) begin
            for (int i = 0; i < WORDS; i++) m_words[i] = digest[i*BW +: BW];
            m_active = 1;
            m_idx    = 0;
         end
         m_prev_dv = digest_valid;
      end
   end

   task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- per-cycle compare + transfer recorder ----------------
   logic [BW-1:0] got [$];
   int            last_seen;
   logic [BW-1:0] last_word;
   bit            cmp_en = 0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk("dout_valid", BW'(dout_valid), BW'(m_active));
         chk("dout_last",  BW'(dout_last),  BW'(m_active && m_idx == WORDS-1));
         chk("busy",       BW'(busy),       BW'(m_active || m_waiting));
         chk("overrun",    BW'(overrun),    BW'(m_ovr));
         if (m_active) chk("dout", dout, present(m_words[m_idx]));
      end
      if (dout_valid && dout_ready) begin
         got.push_back(dout);
         if (dout_last) begin
            last_seen++;
            last_word = dout;
         end
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_rec();
      got.delete();
      last_seen = 0;
      last_word = '0;
   endtask

   function automatic logic [DW-1:0] seq_digest(input int base);
      logic [DW-1:0] d;
      for (int i = 0; i < WORDS; i++) d[i*BW +: BW] = BW'(base + i);
      return d;
   endfunction

   function automatic logic [DW-1:0] rand_digest();
      logic [DW-1:0] d;
      for (int i = 0; i < WORDS; i++) d[i*BW +: BW] = $urandom;
      return d;
   endfunction

   // Compare recorded transfers against the words of d, in order.
   task automatic chk_stream(input string name, input logic [DW-1:0] d);
      chk({name, "_count"}, BW'(got.size()), BW'(WORDS));
      for (int i = 0; i < WORDS && i < got.size(); i++)
         chk(name, got[i], present(d[i*BW +: BW]));
   endtask

   task automatic wait_words(input int n, input string name);
      int k;
      k = 0;
      while (got.size() < n && k < 200) begin
         step();
         k++;
      end
      if (got.size() < n) begin
         errors++;
         $display("FAIL %s_timeout: got %0d words expected %0d", name, got.size(), n);
      end
   endtask

   task automatic pulse_dv(input logic [DW-1:0] d);
      digest       = d;
      digest_valid = 1'b1;
      step();
      digest_valid = 1'b0;
   endtask

   logic [DW-1:0] dig_a, dig_b;

   initial begin
      reset_n = 1'b0; digest_valid = 1'b0; digest = '0;
      new_hash_request = 1'b0; dout_ready = 1'b0;
      step(); step();
      // Reset state
      chk("rst_dout_valid", BW'(dout_valid), '0);
      chk("rst_dout_last",  BW'(dout_last),  '0);
      chk("rst_busy",       BW'(busy),       '0);
      chk("rst_overrun",    BW'(overrun),    '0);
      chk("rst_dout",       dout,            '0);
      reset_n = 1'b1;
      cmp_en  = 1;
      step();

      // Single-cycle digest_valid, always ready
      clear_rec();
      dout_ready = 1'b1;
      pulse_dv(seq_digest(0));
      chk("lat_valid", BW'(dout_valid), 32'd1);
      chk("lat_word0", dout, present(32'h0000_0000));
      for (int i = 0; i < 20; i++) step();
      chk_stream("seq", seq_digest(0));
      chk("last_count", BW'(last_seen), 32'd1);
      chk("last_word",  last_word, present(32'h0000_000F));
      chk("seq_idle_busy", BW'(busy), '0);

      // Toggling ready: order kept, no duplicates or drops
      clear_rec();
      pulse_dv(seq_digest(0));
      for (int i = 0; i < 40; i++) begin
         dout_ready = i[0];
         step();
      end
      dout_ready = 1'b1;
      chk_stream("stall", seq_digest(0));

      // digest_valid held 40 cycles: exactly one readout
      clear_rec();
      digest = seq_digest(32'h100);
      digest_valid = 1'b1;
      for (int i = 0; i < 40; i++) step();
      chk("hold_busy_waitlow", BW'(busy), 32'd1);
      chk("hold_valid_waitlow", BW'(dout_valid), '0);
      digest_valid = 1'b0;
      step(); step();
      chk_stream("hold", seq_digest(32'h100));
      chk("hold_idle", BW'(busy), '0);

      // Overrun on a second rising edge mid-readout
      clear_rec();
      dig_a = seq_digest(32'hA00);
      dig_b = seq_digest(32'hB00);
      pulse_dv(dig_a);
      wait_words(5, "ovr");
      digest = dig_b; digest_valid = 1'b1;
      step(); step();
      digest_valid = 1'b0;
      for (int i = 0; i < 16; i++) step();
      chk_stream("ovr", dig_a);
      chk("ovr_set", BW'(overrun), 32'd1);
      new_hash_request = 1'b1; step(); new_hash_request = 1'b0;
      chk("ovr_clear", BW'(overrun), '0);
      step();

      // Abort at word 7, then reset at word 9, then a clean readout
      clear_rec();
      pulse_dv(seq_digest(32'hC00));
      wait_words(7, "abort");
      new_hash_request = 1'b1; step(); new_hash_request = 1'b0;
      chk("abort_valid", BW'(dout_valid), '0);
      chk("abort_busy",  BW'(busy), '0);
      step();
      clear_rec();
      pulse_dv(seq_digest(32'hD00));
      wait_words(9, "rst");
      reset_n = 1'b0; step(); reset_n = 1'b1;
      chk("rst_mid_valid", BW'(dout_valid), '0);
      chk("rst_mid_busy",  BW'(busy), '0);
      step();
      clear_rec();
      dig_a = seq_digest(32'hE00);
      pulse_dv(dig_a);
      for (int i = 0; i < 18; i++) step();
      chk_stream("after_rst", dig_a);

      // Randomized traffic against the model
      for (int i = 0; i < 1500; i++) begin
         dout_ready       = ($urandom_range(0, 3) != 0);
         new_hash_request = ($urandom_range(0, 60) == 0);
         reset_n          = ($urandom_range(0, 150) != 0);
         if ($urandom_range(0, 9) == 0) digest_valid = ~digest_valid;
         if (!digest_valid) digest = rand_digest();
         step();
      end
      new_hash_request = 1'b0; reset_n = 1'b1; digest_valid = 1'b0;
      step(); step();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/blake2_digest_reader.md
BLAKE2_DIGEST_READER -- requirements
Module: blake2_digest_reader

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, meaning processor bus word width in bits.
REQ-002 SHALL have parameter DIGEST_WIDTH, default 512, meaning hash-engine digest width in bits; an integer multiple of BUS_WIDTH.
REQ-003 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port digest_valid  input  1  engine digest-ready level, held high while the digest is stable.
REQ-006 SHALL have port digest  input  DIGEST_WIDTH  engine digest value.
REQ-007 SHALL have port new_hash_request  input  1  processor abort/restart pulse.
REQ-008 SHALL have port dout_ready  input  1  processor accepts dout this cycle.
REQ-009 SHALL have port dout  output  BUS_WIDTH  current digest word.
REQ-010 SHALL have port dout_valid  output  1  dout holds a valid word.
REQ-011 SHALL have port dout_last  output  1  dout is the final word (index WORDS-1).
REQ-012 SHALL have port busy  output  1  high in SEND or WAIT_LOW.
REQ-013 SHALL have port overrun  output  1  sticky flag: new digest arrived before readout finished.

Function
REQ-014 SHALL define WORDS = DIGEST_WIDTH/BUS_WIDTH and a word pointer of width $clog2(WORDS) (minimum 1).
REQ-015 SHALL use states IDLE, SEND, WAIT_LOW.
REQ-016 IDLE: when digest_valid is sampled high, SHALL capture digest into a shadow register, clear the pointer, and enter SEND; dout_valid SHALL be high the next cycle (1-cycle latency).
REQ-017 SEND: dout SHALL equal shadow[ptr*BUS_WIDTH +: BUS_WIDTH]; word 0 is digest[BUS_WIDTH-1:0].
REQ-018 SEND: a word transfers when dout_valid and dout_ready are both high; the pointer then increments; dout SHALL hold stable while dout_ready is low.
REQ-019 A transfer with ptr == WORDS-1 SHALL end readout: if digest_valid is still high, go to WAIT_LOW; otherwise go to IDLE.
REQ-020 WAIT_LOW: SHALL stay until digest_valid is sampled low, then go to IDLE, so that one digest_valid level is read out exactly once.
REQ-021 dout_last SHALL equal dout_valid AND (ptr == WORDS-1).
REQ-022 overrun SHALL set when SEND sees digest_valid go from low to high (one-cycle registered delay); the new digest SHALL be ignored and the shadow register left unchanged.
REQ-023 new_hash_request SHALL force IDLE, clear the pointer, deassert dout_valid, and clear overrun on the next edge; it has priority over every other event in the same cycle.
REQ-024 If new_hash_request and digest_valid are both high, the abort SHALL win; capture SHALL occur on a later cycle in which digest_valid is high and new_hash_request is low.
REQ-025 The pointer SHALL never wrap past WORDS-1 within one readout.

Reset
REQ-026 When reset_n is low at a clock edge: state=IDLE, ptr=0, dout_valid=0, dout_last=0, busy=0, overrun=0, dout=0, shadow=0.
REQ-027 Reset asserted mid-readout SHALL abandon the readout; after release the block SHALL capture only on digest_valid high in IDLE.

Configuration
REQ-028 Macro DIGEST_READER_BYTESWAP_EN: when defined, each dout word SHALL be byte-reversed (byte 0 to the MSB byte), which converts little-endian BLAKE2 words to the big-endian bus; BUS_WIDTH SHALL then be a multiple of 8. When undefined, dout is the unmodified slice.

Structure
REQ-029 Shared package blake2_pkg SHALL hold the state enum type, the default BUS_WIDTH/DIGEST_WIDTH constants, and the byte-swap function.
REQ-030 No sub-module; one FSM, the shadow register, and the pointer in a single module.

Verification (BUS_WIDTH=32, DIGEST_WIDTH=512, WORDS=16)
REQ-031 digest = {16 words 0x0F..0x00}, digest_valid high 1 cycle, dout_ready=1 -> dout_valid the next cycle; dout 0x00..0x0F over 16 consecutive cycles; dout_last only on 0x0F; then IDLE.
REQ-032 Same digest, dout_ready toggling 1/0 -> 16 words in order, dout held during stalls, no duplicates or drops.
REQ-033 digest_valid held high 40 cycles -> exactly one 16-word readout, WAIT_LOW held until digest_valid falls.
REQ-034 Second digest_valid rising edge at word 5 -> overrun=1; remaining words still from the first digest; new_hash_request clears overrun.
REQ-035 new_hash_request at word 7; separately, reset_n low at word 9 -> dout_valid=0 the next cycle, busy=0; a following digest reads out from word 0.
REQ-036 With DIGEST_READER_BYTESWAP_EN defined, word 0 = 0x11223344 -> dout 0x44332211.
